// File: rtl/adder_checker.sv
// Bit-serial reference checker for an adder/subtractor: captures one observed vector,
// recomputes sum/carry/overflow LSB first and flags any disagreement. Optional CHECK_LOG_EN
// adds first-error capture ports. WIDTH must be at least 2.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | ready high, waiting for valid; verdict of previous vector shown
// SERIAL  | one expected-result bit computed per cycle, LSB first
// COMPARE | expected vs captured result compared; verdict lands on exit
module adder_checker #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic             mode,
    input  logic [WIDTH-1:0] final_sum,
    input  logic             final_carry_out,
    input  logic             overflow,
    input  logic             clear,
    output logic             ready,
    output logic             result_valid,
    output logic             mismatch,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count
`ifdef CHECK_LOG_EN
    ,
    output logic [WIDTH-1:0] first_err_data0,
    output logic [WIDTH-1:0] first_err_data1,
    output logic             first_err_mode,
    output logic [WIDTH-1:0] first_err_sum,
    output logic             first_err_valid
`endif
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SERIAL  = 2'd1,
        S_COMPARE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic             w_accept;
    logic             w_done;
    logic             w_mismatch;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_mode;
    logic [WIDTH-1:0] r_obs_sum;
    logic             r_obs_carry;
    logic             r_obs_ovf;
    logic [BW-1:0]    r_bit_cnt;
    logic             r_carry;
    logic             r_cin_msb;
    logic [WIDTH-1:0] r_exp_sum;

    logic             r_result_valid;
    logic             r_mismatch;
    logic [CNT_W-1:0] r_sample_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_sum_bit;
    logic             w_carry_next;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // clear outranks both a new accept and a pending verdict
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!clear && valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SERIAL;
                end
            end
            S_SERIAL: begin
                if (clear) begin
                    w_state_next = S_IDLE;
                end else if (r_bit_cnt == '0) begin
                    w_state_next = S_COMPARE;
                end
            end
            S_COMPARE: begin
                w_state_next = S_IDLE;
                w_done       = !clear;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign ready = (r_state == S_IDLE);

    // ------------------------------------------------------------------
    // Bit-serial reference adder
    // ------------------------------------------------------------------
    assign w_a_bit      = r_a[0];
    assign w_b_bit      = r_b[0] ^ r_mode;
    assign w_sum_bit    = w_a_bit ^ w_b_bit ^ r_carry;
    assign w_carry_next = (w_a_bit & w_b_bit) | (w_a_bit & r_carry) | (w_b_bit & r_carry);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_mode      <= 1'b0;
            r_obs_sum   <= '0;
            r_obs_carry <= 1'b0;
            r_obs_ovf   <= 1'b0;
            r_bit_cnt   <= '0;
            r_carry     <= 1'b0;
            r_cin_msb   <= 1'b0;
            r_exp_sum   <= '0;
        end else if (w_accept) begin
            r_a         <= data0;
            r_b         <= data1;
            r_mode      <= mode;
            r_obs_sum   <= final_sum;
            r_obs_carry <= final_carry_out;
            r_obs_ovf   <= overflow;
            r_bit_cnt   <= BW'(WIDTH - 1);
            r_carry     <= mode;
            r_cin_msb   <= 1'b0;
            r_exp_sum   <= '0;
        end else if (r_state == S_SERIAL) begin
            r_a       <= r_a >> 1;
            r_b       <= r_b >> 1;
            r_exp_sum <= {w_sum_bit, r_exp_sum[WIDTH-1:1]};
            // last write before COMPARE holds the carry into the MSB
            r_cin_msb <= r_carry;
            r_carry   <= w_carry_next;
            if (r_bit_cnt != '0) begin
                r_bit_cnt <= r_bit_cnt - BW'(1);
            end
        end
    end

    assign w_mismatch = (r_exp_sum != r_obs_sum)
                      | (r_carry != r_obs_carry)
                      | ((r_cin_msb ^ r_carry) != r_obs_ovf);

    // ------------------------------------------------------------------
    // Verdict and saturating counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_result_valid <= 1'b0;
            r_mismatch     <= 1'b0;
            r_sample_cnt   <= '0;
            r_err_cnt      <= '0;
        end else begin
            r_result_valid <= w_done;
            if (w_done) begin
                r_mismatch <= w_mismatch;
                if (r_sample_cnt != CNT_MAX) begin
                    r_sample_cnt <= r_sample_cnt + CNT_W'(1);
                end
                if (w_mismatch && (r_err_cnt != CNT_MAX)) begin
                    r_err_cnt <= r_err_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign result_valid = r_result_valid;
    assign mismatch     = r_mismatch;
    assign sample_count = r_sample_cnt;
    assign err_count    = r_err_cnt;

`ifdef CHECK_LOG_EN
    // operands are shifted away during SERIAL, so keep untouched copies for the log
    logic [WIDTH-1:0] r_d0_hold;
    logic [WIDTH-1:0] r_d1_hold;
    logic [WIDTH-1:0] r_log_d0;
    logic [WIDTH-1:0] r_log_d1;
    logic             r_log_mode;
    logic [WIDTH-1:0] r_log_sum;
    logic             r_log_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_d0_hold <= '0;
            r_d1_hold <= '0;
        end else if (w_accept) begin
            r_d0_hold <= data0;
            r_d1_hold <= data1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_log_d0    <= '0;
            r_log_d1    <= '0;
            r_log_mode  <= 1'b0;
            r_log_sum   <= '0;
            r_log_valid <= 1'b0;
        end else if (w_done && w_mismatch && !r_log_valid) begin
            r_log_d0    <= r_d0_hold;
            r_log_d1    <= r_d1_hold;
            r_log_mode  <= r_mode;
            r_log_sum   <= r_obs_sum;
            r_log_valid <= 1'b1;
        end
    end

    assign first_err_data0 = r_log_d0;
    assign first_err_data1 = r_log_d1;
    assign first_err_mode  = r_log_mode;
    assign first_err_sum   = r_log_sum;
    assign first_err_valid = r_log_valid;
`endif

endmodule

// File: tb/tb_adder_checker.sv
// Scoreboard bench for adder_checker: expected verdicts are queued when a vector is driven
// and popped when result_valid appears. First-error log ports are checked when CHECK_LOG_EN is set.
module tb_adder_checker;

    localparam int W = 8;
    localparam int C = 8;

    logic         clk;
    logic         rst_n;
    logic         valid;
    logic [W-1:0] data0;
    logic [W-1:0] data1;
    logic         mode;
    logic [W-1:0] final_sum;
    logic         final_carry_out;
    logic         overflow;
    logic         clear;
    logic         ready;
    logic         result_valid;
    logic         mismatch;
    logic [C-1:0] sample_count;
    logic [C-1:0] err_count;
`ifdef CHECK_LOG_EN
    logic [W-1:0] first_err_data0;
    logic [W-1:0] first_err_data1;
    logic         first_err_mode;
    logic [W-1:0] first_err_sum;
    logic         first_err_valid;
`endif

    adder_checker #(.WIDTH(W), .CNT_W(C)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid           (valid),
        .data0           (data0),
        .data1           (data1),
        .mode            (mode),
        .final_sum       (final_sum),
        .final_carry_out (final_carry_out),
        .overflow        (overflow),
        .clear           (clear),
        .ready           (ready),
        .result_valid    (result_valid),
        .mismatch        (mismatch),
        .sample_count    (sample_count),
        .err_count       (err_count)
`ifdef CHECK_LOG_EN
        ,
        .first_err_data0 (first_err_data0),
        .first_err_data1 (first_err_data1),
        .first_err_mode  (first_err_mode),
        .first_err_sum   (first_err_sum),
        .first_err_valid (first_err_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic sb_q[$];
    int   m_samples = 0;
    int   m_errs    = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // golden arithmetic: returns {ovf, carry, sum}
    function automatic logic [W+1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b, input logic md);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic [W-1:0] low;
        bb   = md ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, md};
        low  = {1'b0, a[W-2:0]} + {1'b0, bb[W-2:0]} + {{(W-1){1'b0}}, md};
        return {low[W-1] ^ full[W], full[W], full[W-1:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready;
        int w;
        w = 0;
        while (!ready && w < 50) begin
            tick();
            w++;
        end
        check_eq("ready_wait", {31'd0, ready}, 32'd1);
    endtask

    task automatic run_vec(input logic [W-1:0] d0, input logic [W-1:0] d1, input logic md,
                           input logic [W-1:0] s, input logic c, input logic o);
        logic [W+1:0] g;
        logic         exp_mm;
        logic         got;
        int           lat;
        g      = golden(d0, d1, md);
        exp_mm = (g[W-1:0] != s) || (g[W] != c) || (g[W+1] != o);
        wait_ready();
        sb_q.push_back(exp_mm);
        valid = 1'b1; data0 = d0; data1 = d1; mode = md;
        final_sum = s; final_carry_out = c; overflow = o;
        tick();
        valid = 1'b0;
        data0 = W'($urandom); data1 = W'($urandom); mode = 1'($urandom);
        final_sum = W'($urandom); final_carry_out = 1'($urandom); overflow = 1'($urandom);
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (result_valid) begin
                got = 1'b1;
                lat = k;
                break;
            end
        end
        check_eq("rv_seen", {31'd0, got}, 32'd1);
        if (sb_q.size() > 0) exp_mm = sb_q.pop_front();
        if (got) begin
            check_eq("latency", lat, 32'd9);
            check_eq("ready_at_rv", {31'd0, ready}, 32'd1);
            check_eq("mismatch", {31'd0, mismatch}, {31'd0, exp_mm});
            if (m_samples < 255) m_samples++;
            if (exp_mm && m_errs < 255) m_errs++;
            check_eq("sample_count", {24'd0, sample_count}, m_samples);
            check_eq("err_count", {24'd0, err_count}, m_errs);
            tick();
            check_eq("rv_pulse", {31'd0, result_valid}, 32'd0);
            check_eq("mismatch_hold", {31'd0, mismatch}, {31'd0, exp_mm});
        end
    endtask

    task automatic no_rv_window(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            if (result_valid) pulses++;
        end
        check_eq(tag, pulses, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W+1:0] g;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         md;
        int           kind;
        int           accepts;
        int           pulses;
        int           acc_cyc[3];

        rst_n = 1'b0; valid = 1'b0; data0 = '0; data1 = '0; mode = 1'b0;
        final_sum = '0; final_carry_out = 1'b0; overflow = 1'b0; clear = 1'b0;
        repeat (3) tick();
        check_eq("rst_ready", {31'd0, ready}, 32'd1);
        check_eq("rst_rv", {31'd0, result_valid}, 32'd0);
        check_eq("rst_mismatch", {31'd0, mismatch}, 32'd0);
        check_eq("rst_samples", {24'd0, sample_count}, 32'd0);
        check_eq("rst_errs", {24'd0, err_count}, 32'd0);
        rst_n = 1'b1;
        tick();

        // directed arithmetic cases
        run_vec(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
        run_vec(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_vec(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0);
        run_vec(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        run_vec(8'h00, 8'hFF, 1'b1, 8'h01, 1'b0, 1'b0);
        run_vec(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_vec(8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0);

        // random vectors, some with a single corrupted field
        for (int i = 0; i < 12; i++) begin
            a    = W'($urandom);
            b    = W'($urandom);
            md   = 1'($urandom);
            g    = golden(a, b, md);
            kind = $urandom_range(0, 3);
            if (kind == 1) g[$urandom_range(0, W-1)] ^= 1'b1;
            if (kind == 2) g[W] ^= 1'b1;
            if (kind == 3) g[W+1] ^= 1'b1;
            run_vec(a, b, md, g[W-1:0], g[W], g[W+1]);
        end

        // valid held for 30 cycles: accepts at 0, 10, 20 only
        wait_ready();
        accepts = 0;
        pulses  = 0;
        acc_cyc = '{-1, -1, -1};
        valid = 1'b1; data0 = 8'h05; data1 = 8'h03; mode = 1'b0;
        final_sum = 8'h08; final_carry_out = 1'b0; overflow = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (valid && ready) begin
                if (accepts < 3) acc_cyc[accepts] = cyc;
                accepts++;
            end
            tick();
            if (result_valid) pulses++;
        end
        valid = 1'b0;
        check_eq("held_accepts", accepts, 32'd3);
        check_eq("held_acc1", acc_cyc[1], 32'd10);
        check_eq("held_acc2", acc_cyc[2], 32'd20);
        check_eq("held_pulses", pulses, 32'd3);
        m_samples += 3;
        check_eq("held_samples", {24'd0, sample_count}, m_samples);
        check_eq("held_errs", {24'd0, err_count}, m_errs);

        // clear together with valid: no accept, counters zeroed
        valid = 1'b1; clear = 1'b1;
        tick();
        valid = 1'b0; clear = 1'b0;
        check_eq("clracc_ready", {31'd0, ready}, 32'd1);
        check_eq("clracc_samples", {24'd0, sample_count}, 32'd0);
        m_samples = 0;
        m_errs    = 0;
        no_rv_window("clracc_no_rv", 12);

        // clear on the edge that would deliver the verdict
        run_vec(8'h10, 8'h20, 1'b0, 8'h31, 1'b0, 1'b0);
        wait_ready();
        valid = 1'b1; data0 = 8'h10; data1 = 8'h20; mode = 1'b0;
        final_sum = 8'h00; final_carry_out = 1'b0; overflow = 1'b0;
        tick();
        valid = 1'b0;
        repeat (8) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("clrrv_rv", {31'd0, result_valid}, 32'd0);
        check_eq("clrrv_samples", {24'd0, sample_count}, 32'd0);
        check_eq("clrrv_errs", {24'd0, err_count}, 32'd0);
        check_eq("clrrv_mismatch", {31'd0, mismatch}, 32'd0);
        check_eq("clrrv_ready", {31'd0, ready}, 32'd1);
        m_samples = 0;
        m_errs    = 0;
        no_rv_window("clrrv_no_rv", 12);

        // reset while the bit-4 step would be taken
        run_vec(8'h01, 8'h01, 1'b0, 8'h03, 1'b0, 1'b0);
        wait_ready();
        valid = 1'b1; data0 = 8'h01; data1 = 8'h02; mode = 1'b0;
        final_sum = 8'h03; final_carry_out = 1'b0; overflow = 1'b0;
        tick();
        valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("rstser_ready", {31'd0, ready}, 32'd1);
        check_eq("rstser_samples", {24'd0, sample_count}, 32'd0);
        check_eq("rstser_errs", {24'd0, err_count}, 32'd0);
        check_eq("rstser_mismatch", {31'd0, mismatch}, 32'd0);
        m_samples = 0;
        m_errs    = 0;
        no_rv_window("rstser_no_rv", 12);

`ifdef CHECK_LOG_EN
        check_eq("log_rst_valid", {31'd0, first_err_valid}, 32'd0);
        run_vec(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
        check_eq("log_good_valid", {31'd0, first_err_valid}, 32'd0);
        run_vec(8'h10, 8'h20, 1'b0, 8'h31, 1'b0, 1'b0);
        run_vec(8'h33, 8'h44, 1'b1, 8'h00, 1'b0, 1'b0);
        check_eq("log_d0", {24'd0, first_err_data0}, 32'h10);
        check_eq("log_d1", {24'd0, first_err_data1}, 32'h20);
        check_eq("log_mode", {31'd0, first_err_mode}, 32'd0);
        check_eq("log_sum", {24'd0, first_err_sum}, 32'h31);
        check_eq("log_valid", {31'd0, first_err_valid}, 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("log_clr_valid", {31'd0, first_err_valid}, 32'd0);
        m_samples = 0;
        m_errs    = 0;
`endif

        // saturation: 260 mismatching vectors
        for (int i = 0; i < 260; i++) begin
            run_vec(8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 1'b0);
        end
        check_eq("sat_samples", {24'd0, sample_count}, 32'hFF);
        check_eq("sat_errs", {24'd0, err_count}, 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
